blake2s_msg_feeder: RTL and testbench
=====================================

Name: blake2s_msg_feeder

Overview:
- Upstream driver for the BLAKE2s-256 hash wrapper.
- Accepts a byte-stream message on a valid/ready interface and splits it into 64-byte blocks with zero padding on the final block.
- Drives the core's byte-write port with block_first/block_last and the cumulative byte count ll.
- Captures the digest bytes the core streams back and re-emits them as a framed output stream.

Parameters:
- NN_MAX, 32, maximum digest length in bytes; nn_i is clamped to 1..NN_MAX.
- BB, 64, block size in bytes; fixed for BLAKE2s, and data_idx width is log2(BB).

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- kk_i  in  8  key length; latched at message start and forwarded unchanged
- nn_i  in  8  digest length in bytes; latched at message start
- s_valid_i  in  1  message byte valid
- s_ready_o  out  1  feeder accepts a byte this cycle
- s_data_i  in  8  message byte
- s_last_i  in  1  marks the final message byte
- kk_o  out  8  latched kk to core
- nn_o  out  8  latched nn to core
- ll_o  out  64  cumulative message bytes through the current block
- block_first_o  out  1  current block is the first block
- block_last_o  out  1  current block is the last block
- data_v_o  out  1  byte write strobe to core
- data_idx_o  out  6  byte index within the block
- data_o  out  8  byte to core
- core_ready_i  in  1  core is idle and can accept a new block
- finished_i  in  1  core digest is available
- h_i  in  8  core digest byte
- hash_v_o  out  1  digest byte valid
- hash_o  out  8  digest byte
- hash_last_o  out  1  final digest byte

Behaviour:
- Reset values: every output is 0, except block_first_o=1; state is IDLE.
- Interface facts:
  - The core samples kk/nn/ll/block_first/block_last on the data_v_o cycle with data_idx_o==63.
  - It starts compression after that write and drops core_ready_i from the next cycle until done.
  - After the final block, the core raises finished_i and presents digest byte k on h_i at cycle k after finished_i's rising edge, for k = 0..nn-1.
- All core-side outputs are registered: a byte accepted in cycle t appears on data_v_o in cycle t+1.
- States:
  - IDLE: s_ready_o=0. On s_valid_i && core_ready_i: latch kk/nn, set ll=0 and block_first=1, go FILL.
  - FILL: s_ready_o = core_ready_i.
    - Each accepted byte writes index idx, then idx++ and ll++.
    - s_last_i with idx==63: block_last=1, go WAIT_HASH.
    - s_last_i with idx<63: block_last=1, go PAD.
    - idx==63 and not last: go WAIT_CORE.
  - PAD: s_ready_o=0. Write 0x00 at idx..63, one per cycle; ll is unchanged; after idx 63, go WAIT_HASH.
  - WAIT_CORE: s_ready_o=0. Clear block_first, reset idx=0. Return to FILL once core_ready_i has fallen and risen again.
  - WAIT_HASH: wait for the finished_i rising edge, then go DRAIN.
  - DRAIN:
    - Register h_i to hash_o with hash_v_o=1 for nn cycles.
    - hash_last_o=1 on byte nn-1.
    - Then go IDLE with block_first=1.
    - No backpressure is applied on the hash output.
- Boundaries:
  - Message of exactly 64·n bytes: no extra pad block; ll_o=64·n.
  - 1-byte message: 1 data write, then 63 pad writes; ll_o=1.
  - Empty messages are unsupported; s_last always accompanies a byte.
  - nn_i=0 is treated as 1.
  - nn_i>NN_MAX is clamped to NN_MAX.
  - ll wraps mod 2^64; this is out of scope.
  - s_valid_i is ignored outside IDLE/FILL.
  - finished_i outside WAIT_HASH is ignored.
  - Reset mid-message aborts immediately to the reset values; any partial block is discarded.

Optional Feature:
- Macro: BLAKE2S_FEEDER_PERF_EN.
- With it: extra output perf_cycles_o[31:0] counts cycles from leaving IDLE to hash_last_o, inclusive.
  - Held until the next message start, then cleared.
  - Saturates at 0xFFFFFFFF.
  - Reset value 0.
- Without it: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package blake2s_pkg holds:
  - BB=64 and the IDX_W=6 constant.
  - The feeder state enum (IDLE, FILL, PAD, WAIT_CORE, WAIT_HASH, DRAIN).
  - NN_MAX.
- One sub-module, blake2s_digest_capture, owns the WAIT_HASH/DRAIN byte counter and output framing, and is started by a pulse from the main FSM.

Test Plan:
- "abc" (0x61 0x62 0x63, s_last on 0x63), kk=0, nn=32, with the real core:
  - 3 data writes, then pad indices 3..63 with 0x00.
  - block_first=block_last=1, ll_o=3.
  - 32 hash bytes 50 8c 5e 8c … 59 82; hash_last on byte 31.
- 64-byte message 0x00..0x3F with a core model:
  - Exactly one block, no pad writes, block_last=1, ll_o=64.
- 65-byte message with core_ready_i held low 20 cycles after each block:
  - Block 0: first=1, last=0, ll=64.
  - s_ready_o stays 0 while core busy.
  - Block 1: first=0, last=1, ll=65; 63 pad writes.
- nn_i=0 and nn_i=40: exactly 1 and 32 hash_v_o cycles respectively; hash_last_o on the final one.
- Random s_valid_i gaps during FILL: data_idx_o strictly increments 0..63 with no duplicates or skips.
- nreset pulsed during PAD: all outputs return to reset values within the reset cycle; the next 1-byte message hashes correctly.

Source files
------------

// File: rtl/blake2s_pkg.sv
// Shared constants, feeder state encoding and the digest-length clamp for the BLAKE2s message feeder.
// Purely declarative: no latency, no flow control.
// Backpressure: not applicable.
package blake2s_pkg;

    localparam int BB     = 64;
    localparam int IDX_W  = 6;
    localparam int NN_MAX = 32;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BB - 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        PAD,
        WAIT_CORE,
        WAIT_HASH,
        DRAIN
    } feeder_state_e;

    // A zero-length digest is meaningless, so it is promoted to one byte.
    function automatic logic [7:0] clamp_nn(input logic [7:0] nn);
        if (nn == 8'd0) begin
            return 8'd1;
        end
        if (nn > 8'(NN_MAX)) begin
            return 8'(NN_MAX);
        end
        return nn;
    endfunction

endpackage

// File: rtl/blake2s_digest_capture.sv
// Captures nn digest bytes from the core after a start pulse and frames them as a byte stream.
// Latency: h_i byte k appears on hash_o one cycle after it is presented; done_o marks the last byte.
// Backpressure: none, the output stream is never stalled.
module blake2s_digest_capture
    import blake2s_pkg::*;
(
    input  logic       clk,
    input  logic       nreset,
    input  logic       start_i,
    input  logic [7:0] nn_i,
    input  logic [7:0] h_i,
    output logic       done_o,
    output logic       hash_v_o,
    output logic [7:0] hash_o,
    output logic       hash_last_o
);

    logic       active_q, active_d;
    logic [7:0] cnt_q, cnt_d;
    logic       hash_v_q, hash_v_d;
    logic [7:0] hash_q, hash_d;
    logic       hash_last_q, hash_last_d;
    logic [7:0] cur;

    always_comb begin
        active_d    = active_q;
        cnt_d       = cnt_q;
        hash_v_d    = 1'b0;
        hash_d      = 8'd0;
        hash_last_d = 1'b0;
        cur         = cnt_q;
        if (start_i || active_q) begin
            // The start cycle already carries digest byte 0.
            cur      = start_i ? 8'd0 : cnt_q;
            hash_v_d = 1'b1;
            hash_d   = h_i;
            if (cur == nn_i - 8'd1) begin
                hash_last_d = 1'b1;
                active_d    = 1'b0;
                cnt_d       = 8'd0;
            end else begin
                active_d = 1'b1;
                cnt_d    = cur + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            active_q    <= 1'b0;
            cnt_q       <= 8'd0;
            hash_v_q    <= 1'b0;
            hash_q      <= 8'd0;
            hash_last_q <= 1'b0;
        end else begin
            active_q    <= active_d;
            cnt_q       <= cnt_d;
            hash_v_q    <= hash_v_d;
            hash_q      <= hash_d;
            hash_last_q <= hash_last_d;
        end
    end

    assign hash_v_o    = hash_v_q;
    assign hash_o      = hash_q;
    assign hash_last_o = hash_last_q;
    assign done_o      = hash_last_q;

endmodule

// File: rtl/blake2s_msg_feeder.sv
// Splits a byte stream into zero-padded 64-byte BLAKE2s blocks for the core and re-emits the digest; BLAKE2S_FEEDER_PERF_EN adds perf_cycles_o.
// Latency: an accepted byte is written to the core one cycle later; digest bytes lag h_i by one cycle.
// Backpressure: s_ready_o follows core_ready_i only while filling a block; the digest output has none.
module blake2s_msg_feeder
    import blake2s_pkg::*;
(
    input  logic             clk,
    input  logic             nreset,
    input  logic [7:0]       kk_i,
    input  logic [7:0]       nn_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [7:0]       s_data_i,
    input  logic             s_last_i,
    output logic [7:0]       kk_o,
    output logic [7:0]       nn_o,
    output logic [63:0]      ll_o,
    output logic             block_first_o,
    output logic             block_last_o,
    output logic             data_v_o,
    output logic [IDX_W-1:0] data_idx_o,
    output logic [7:0]       data_o,
    input  logic             core_ready_i,
    input  logic             finished_i,
    input  logic [7:0]       h_i,
    output logic             hash_v_o,
    output logic [7:0]       hash_o,
    output logic             hash_last_o
`ifdef BLAKE2S_FEEDER_PERF_EN
    ,
    output logic [31:0]      perf_cycles_o
`endif
);

    feeder_state_e    state_q, state_d;
    logic [7:0]       kk_q, kk_d;
    logic [7:0]       nn_q, nn_d;
    logic [63:0]      ll_q, ll_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             seen_low_q, seen_low_d;
    logic             fin_prev_q;
    logic             dv_q, dv_d;
    logic [IDX_W-1:0] didx_q, didx_d;
    logic [7:0]       dat_q, dat_d;
    logic             cap_start;
    logic             cap_done;

    always_comb begin
        state_d    = state_q;
        kk_d       = kk_q;
        nn_d       = nn_q;
        ll_d       = ll_q;
        first_d    = first_q;
        last_d     = last_q;
        idx_d      = idx_q;
        seen_low_d = seen_low_q;
        dv_d       = 1'b0;
        didx_d     = '0;
        dat_d      = 8'd0;
        s_ready_o  = 1'b0;
        cap_start  = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_valid_i && core_ready_i) begin
                    kk_d    = kk_i;
                    nn_d    = clamp_nn(nn_i);
                    ll_d    = 64'd0;
                    first_d = 1'b1;
                    last_d  = 1'b0;
                    idx_d   = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                s_ready_o = core_ready_i;
                if (s_valid_i && core_ready_i) begin
                    dv_d   = 1'b1;
                    didx_d = idx_q;
                    dat_d  = s_data_i;
                    ll_d   = ll_q + 64'd1;
                    idx_d  = idx_q + 1'b1;
                    if (s_last_i) begin
                        last_d  = 1'b1;
                        state_d = (idx_q == IDX_LAST) ? WAIT_HASH : PAD;
                    end else if (idx_q == IDX_LAST) begin
                        seen_low_d = 1'b0;
                        state_d    = WAIT_CORE;
                    end
                end
            end
            PAD: begin
                dv_d   = 1'b1;
                didx_d = idx_q;
                idx_d  = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = WAIT_HASH;
                end
            end
            WAIT_CORE: begin
                // The core has already sampled block_first with the idx 63 write.
                first_d = 1'b0;
                idx_d   = '0;
                if (!core_ready_i) begin
                    seen_low_d = 1'b1;
                end
                if (seen_low_q && core_ready_i) begin
                    state_d = FILL;
                end
            end
            WAIT_HASH: begin
                if (finished_i && !fin_prev_q) begin
                    cap_start = 1'b1;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                if (cap_done) begin
                    first_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= IDLE;
            kk_q       <= 8'd0;
            nn_q       <= 8'd0;
            ll_q       <= 64'd0;
            first_q    <= 1'b1;
            last_q     <= 1'b0;
            idx_q      <= '0;
            seen_low_q <= 1'b0;
            fin_prev_q <= 1'b0;
            dv_q       <= 1'b0;
            didx_q     <= '0;
            dat_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            kk_q       <= kk_d;
            nn_q       <= nn_d;
            ll_q       <= ll_d;
            first_q    <= first_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
            seen_low_q <= seen_low_d;
            fin_prev_q <= finished_i;
            dv_q       <= dv_d;
            didx_q     <= didx_d;
            dat_q      <= dat_d;
        end
    end

    assign kk_o          = kk_q;
    assign nn_o          = nn_q;
    assign ll_o          = ll_q;
    assign block_first_o = first_q;
    assign block_last_o  = last_q;
    assign data_v_o      = dv_q;
    assign data_idx_o    = didx_q;
    assign data_o        = dat_q;

    blake2s_digest_capture u_capture (
        .clk         (clk),
        .nreset      (nreset),
        .start_i     (cap_start),
        .nn_i        (nn_q),
        .h_i         (h_i),
        .done_o      (cap_done),
        .hash_v_o    (hash_v_o),
        .hash_o      (hash_o),
        .hash_last_o (hash_last_o)
    );

`ifdef BLAKE2S_FEEDER_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Every non-IDLE cycle belongs to the message, up to and including the hash_last cycle in DRAIN.
    always_comb begin
        perf_d = perf_q;
        if (state_q == IDLE && state_d == FILL) begin
            perf_d = 32'd0;
        end else if (state_q != IDLE && perf_q != 32'hFFFF_FFFF) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            perf_q <= 32'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_blake2s_msg_feeder.sv
// Randomised scoreboard bench for blake2s_msg_feeder with a behavioural core model driving ready/finished/h.
`timescale 1ns/1ps
module tb_blake2s_msg_feeder;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic [7:0]  kk_i = 8'd0, nn_i = 8'd0;
    logic        s_valid_i = 1'b0, s_last_i = 1'b0;
    logic [7:0]  s_data_i = 8'd0;
    logic        s_ready_o;
    logic [7:0]  kk_o, nn_o;
    logic [63:0] ll_o;
    logic        block_first_o, block_last_o, data_v_o;
    logic [5:0]  data_idx_o;
    logic [7:0]  data_o;
    logic        core_ready_i, finished_i;
    logic [7:0]  h_i;
    logic        hash_v_o, hash_last_o;
    logic [7:0]  hash_o;
`ifdef BLAKE2S_FEEDER_PERF_EN
    logic [31:0] perf_cycles_o;
`endif

    always #5 clk = ~clk;

    blake2s_msg_feeder dut (
        .clk(clk), .nreset(nreset), .kk_i(kk_i), .nn_i(nn_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_last_i(s_last_i),
        .kk_o(kk_o), .nn_o(nn_o), .ll_o(ll_o), .block_first_o(block_first_o), .block_last_o(block_last_o),
        .data_v_o(data_v_o), .data_idx_o(data_idx_o), .data_o(data_o),
        .core_ready_i(core_ready_i), .finished_i(finished_i), .h_i(h_i),
        .hash_v_o(hash_v_o), .hash_o(hash_o), .hash_last_o(hash_last_o)
`ifdef BLAKE2S_FEEDER_PERF_EN
        , .perf_cycles_o(perf_cycles_o)
`endif
    );

    typedef struct {
        int              idx;
        logic [7:0]      data;
        bit              chk;
        bit              first;
        bit              last;
        longint unsigned ll;
        logic [7:0]      kk;
        logic [7:0]      nn;
    } wr_t;

    typedef struct {
        logic [7:0] data;
        bit         last;
    } hs_t;

    wr_t        wr_q[$];
    hs_t        hs_q[$];
    logic [7:0] msg_q[$];
    logic [7:0] digest[32];
    int         busy_cyc = 5;
    int         n_checks = 0;
    int         n_fail = 0;
    wr_t        mon_w;
    hs_t        mon_h;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes a byte or emits a digest byte.
    always @(negedge clk) begin
        if (nreset) begin
            if (!core_ready_i) check("s_ready_while_core_busy", s_ready_o, 0);
            if (data_v_o) begin
                check("write_expected", wr_q.size() != 0, 1);
                if (wr_q.size() != 0) begin
                    mon_w = wr_q.pop_front();
                    check("data_idx", data_idx_o, mon_w.idx);
                    check("data_byte", data_o, mon_w.data);
                    if (mon_w.chk) begin
                        check("block_first", block_first_o, mon_w.first);
                        check("block_last", block_last_o, mon_w.last);
                        check("ll", ll_o, mon_w.ll);
                        check("kk_o", kk_o, mon_w.kk);
                        check("nn_o", nn_o, mon_w.nn);
                    end
                end
            end
            if (hash_v_o) begin
                check("hash_expected", hs_q.size() != 0, 1);
                if (hs_q.size() != 0) begin
                    mon_h = hs_q.pop_front();
                    check("hash_byte", hash_o, mon_h.data);
                    check("hash_last", hash_last_o, mon_h.last);
                end
            end else begin
                check("hash_last_without_valid", hash_last_o, 0);
            end
        end
    end

    // Core model: busy after each idx 63 write, then streams digest byte k k cycles after finished rises.
    initial begin
        int  pend;
        int  busy_cnt;
        bit  busy_last;
        int  fin_k;
        pend = 0; busy_cnt = 0; busy_last = 0; fin_k = -1;
        core_ready_i = 1'b1; finished_i = 1'b0; h_i = 8'd0;
        forever begin
            @(posedge clk); #1;
            if (!nreset) begin
                pend = 0; busy_cnt = 0; fin_k = -1;
                core_ready_i = 1'b1; finished_i = 1'b0; h_i = 8'd0;
            end else begin
                if (fin_k >= 0) begin
                    if (fin_k < 32) begin
                        finished_i = 1'b1; h_i = digest[fin_k]; fin_k++;
                    end else begin
                        finished_i = 1'b0; h_i = 8'd0; core_ready_i = 1'b1; fin_k = -1;
                    end
                end else if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0) begin
                        if (busy_last) fin_k = 0;
                        else core_ready_i = 1'b1;
                    end
                end
                if (pend != 0) begin
                    core_ready_i = 1'b0; busy_cnt = busy_cyc; busy_last = (pend == 2); pend = 0;
                end
                if (data_v_o && data_idx_o == 6'd63) pend = block_last_o ? 2 : 1;
            end
        end
    end

    // Reference: block b holds message bytes 64b..64b+63, zero beyond the end; ll is bytes through that block.
    task automatic send_msg(input logic [7:0] kk, input logic [7:0] nn, input int gap_pct);
        int         len;
        int         nblk;
        int         pos;
        int         t;
        bit         acc;
        logic [7:0] nne;
        wr_t        e;
        hs_t        h;
        len  = msg_q.size();
        nblk = (len + 63) / 64;
        nne  = (nn == 0) ? 8'd1 : (nn > 32) ? 8'd32 : nn;
        for (int b = 0; b < nblk; b++) begin
            for (int i = 0; i < 64; i++) begin
                pos     = b * 64 + i;
                e.idx   = i;
                e.data  = (pos < len) ? msg_q[pos] : 8'd0;
                e.chk   = (i == 63);
                e.first = (b == 0);
                e.last  = (b == nblk - 1);
                e.ll    = (b == nblk - 1) ? longint'(len) : longint'(64 * (b + 1));
                e.kk    = kk;
                e.nn    = nne;
                wr_q.push_back(e);
            end
        end
        for (int k = 0; k < int'(nne); k++) begin
            h.data = digest[k];
            h.last = (k == int'(nne) - 1);
            hs_q.push_back(h);
        end
        kk_i = kk; nn_i = nn;
        for (int i = 0; i < len; i++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                s_valid_i = 1'b0;
                @(posedge clk); #1;
            end
            s_valid_i = 1'b1; s_data_i = msg_q[i]; s_last_i = (i == len - 1);
            t = 0; acc = 0;
            while (!acc && t < 2000) begin
                @(negedge clk); acc = s_ready_o;
                @(posedge clk); #1; t++;
            end
            check("byte_accepted", acc, 1);
        end
        s_valid_i = 1'b0; s_last_i = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((wr_q.size() != 0 || hs_q.size() != 0) && t < 5000) begin
            @(posedge clk); #1; t++;
        end
        check("message_drained", (wr_q.size() == 0 && hs_q.size() == 0), 1);
        t = 0;
        while ((!core_ready_i || finished_i) && t < 200) begin
            @(posedge clk); #1; t++;
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_s_ready"}, s_ready_o, 0);
        check({tag, "_kk"}, kk_o, 0);
        check({tag, "_nn"}, nn_o, 0);
        check({tag, "_ll"}, ll_o, 0);
        check({tag, "_first"}, block_first_o, 1);
        check({tag, "_last"}, block_last_o, 0);
        check({tag, "_data_v"}, data_v_o, 0);
        check({tag, "_data_idx"}, data_idx_o, 0);
        check({tag, "_data"}, data_o, 0);
        check({tag, "_hash_v"}, hash_v_o, 0);
        check({tag, "_hash"}, hash_o, 0);
        check({tag, "_hash_last"}, hash_last_o, 0);
    endtask

    task automatic rand_digest();
        for (int k = 0; k < 32; k++) digest[k] = 8'($urandom);
    endtask

    task automatic rand_msg(input int len);
        msg_q.delete();
        for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
    endtask

    initial begin
        logic [255:0] abc_dig;
        int           t;
        abc_dig = 256'h508c5e8c327c14e2e1a72ba34eeb452f37458b209ed63a294d999b4c86675982;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        nreset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // "abc", one padded block, known digest.
        for (int k = 0; k < 32; k++) digest[k] = abc_dig[255 - 8 * k -: 8];
        msg_q.delete();
        msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
        send_msg(8'd0, 8'd32, 0);
        wait_done();

        // Exactly one full block: no pad block.
        rand_digest();
        msg_q.delete();
        for (int i = 0; i < 64; i++) msg_q.push_back(8'(i));
        send_msg(8'd0, 8'd32, 0);
        wait_done();

        // 65 bytes with a long core busy period between blocks.
        busy_cyc = 20;
        rand_digest(); rand_msg(65);
        send_msg(8'($urandom_range(0, 32)), 8'd32, 0);
        wait_done();
        busy_cyc = 5;

        // Digest length clamps.
        rand_digest(); rand_msg(10);
        send_msg(8'd0, 8'd0, 0);
        wait_done();
        rand_digest(); rand_msg(70);
        send_msg(8'd5, 8'd40, 0);
        wait_done();

        // Random valid gaps across several blocks.
        rand_digest(); rand_msg(150);
        send_msg(8'd16, 8'd20, 40);
        wait_done();

        // Reset in the middle of padding, then a fresh 1-byte message.
        rand_digest(); rand_msg(1);
        send_msg(8'd0, 8'd32, 0);
        t = 0;
        while (!(data_v_o && data_idx_o == 6'd10) && t < 200) begin
            @(posedge clk); #1; t++;
        end
        check("pad_reached_idx10", data_idx_o, 10);
        #1 nreset = 1'b0;
        #1 check_reset("mid_pad_reset");
        wr_q.delete(); hs_q.delete();
        @(posedge clk); #1;
        nreset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rand_digest(); rand_msg(1);
        send_msg(8'd3, 8'd32, 0);
        wait_done();

        // Random lengths, keys, digest sizes and gaps.
        for (int r = 0; r < 6; r++) begin
            busy_cyc = $urandom_range(2, 12);
            rand_digest(); rand_msg($urandom_range(1, 200));
            send_msg(8'($urandom_range(0, 32)), 8'($urandom_range(0, 45)), $urandom_range(0, 50));
            wait_done();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
